// File: rtl/wb_stage.sv
// Write-back stage: one pipeline register behind MEM, load alignment, GPR write port,
// CP0 commit (exception / ERET / MTC0 / MFC0), MEM flush request and difftest trace.
module wb_stage #(
  parameter bit TRACE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_in,
  output logic        wb_allowin_out,
  input  logic [31:0] mem_PC_in,
  input  logic [31:0] mem_dm_data_in,
  input  logic [4:0]  mem_wnum_in,
  input  logic [2:0]  mem_sel_wbdata_in,
  input  logic [7:0]  mem_onehot_in,
  input  logic [4:0]  mem_lubhw_con_in,
  input  logic [1:0]  mem_adrl_in,
  input  logic [2:0]  mem_write_type_in,
  input  logic [31:0] mem_wbdata_in,
  input  logic [3:0]  mem_llr_we_in,
  input  logic        mem_exception_in,
  input  logic        mem_bd_in,
  input  logic        mem_eret_in,
  input  logic [4:0]  mem_ExcCode_in,
  input  logic [7:0]  mem_cp0_addr_in,
  input  logic [31:0] mem_mtc0_data_in,
  input  logic [31:0] mem_error_VAddr_in,
  input  logic [1:0]  mem_mftc0_op_in,
  input  logic [31:0] cp0_rdata_in,
  output logic [3:0]  rf_we_out,
  output logic [4:0]  rf_waddr_out,
  output logic [31:0] rf_wdata_out,
  output logic [7:0]  cp0_addr_out,
  output logic        cp0_we_out,
  output logic [31:0] cp0_wdata_out,
  output logic        cp0_exc_out,
  output logic        cp0_eret_out,
  output logic [4:0]  cp0_ExcCode_out,
  output logic        cp0_bd_out,
  output logic [31:0] cp0_epc_out,
  output logic [31:0] cp0_badvaddr_out,
  output logic [1:0]  wb_ClrStpJmp_out,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dm;
    logic [4:0]  wnum;
    logic [2:0]  sel;
    logic [7:0]  onehot;
    logic [4:0]  lubhw;
    logic [1:0]  adrl;
    logic        wr_gpr;
    logic [31:0] wbdata;
    logic [3:0]  llr_we;
    logic        exception;
    logic        bd;
    logic        eret;
    logic [4:0]  exc_code;
    logic [7:0]  cp0_addr;
    logic [31:0] mtc0_data;
    logic [31:0] err_vaddr;
    logic [1:0]  mftc0_op;
  } wb_payload_t;

  logic        valid_q, valid_d;
  wb_payload_t payload_q, payload_d;
  logic        ready;
  logic        commit;
  logic        flush;
  logic        unused_write_type;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] llr_data;
  logic [31:0] wdata;
  logic [3:0]  we_raw;

  assign ready             = 1'b1;
  assign unused_write_type = &{1'b0, mem_write_type_in[2:1]};
  assign wb_allowin_out    = rst_n & (~valid_q | ready);
  assign commit            = rst_n & valid_q;

  // Exception outranks ERET, so at most one flush bit is ever raised.
  assign cp0_exc_out      = commit & payload_q.exception;
  assign cp0_eret_out     = commit & payload_q.eret & ~payload_q.exception;
  assign wb_ClrStpJmp_out = {cp0_eret_out, cp0_exc_out};
  assign flush            = |wb_ClrStpJmp_out;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (flush)               valid_d = 1'b0;
    else if (wb_allowin_out) valid_d = mem_valid_in;
    if (wb_allowin_out) begin
      payload_d = '0;
      if (mem_valid_in && !flush) begin
        payload_d.pc        = mem_PC_in;
        payload_d.dm        = mem_dm_data_in;
        payload_d.wnum      = mem_wnum_in;
        payload_d.sel       = mem_sel_wbdata_in;
        payload_d.onehot    = mem_onehot_in;
        payload_d.lubhw     = mem_lubhw_con_in;
        payload_d.adrl      = mem_adrl_in;
        payload_d.wr_gpr    = mem_write_type_in[0];
        payload_d.wbdata    = mem_wbdata_in;
        payload_d.llr_we    = mem_llr_we_in;
        payload_d.exception = mem_exception_in;
        payload_d.bd        = mem_bd_in;
        payload_d.eret      = mem_eret_in;
        payload_d.exc_code  = mem_ExcCode_in;
        payload_d.cp0_addr  = mem_cp0_addr_in;
        payload_d.mtc0_data = mem_mtc0_data_in;
        payload_d.err_vaddr = mem_error_VAddr_in;
        payload_d.mftc0_op  = mem_mftc0_op_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  always_comb begin
    load_byte = payload_q.dm[{payload_q.adrl, 3'b000} +: 8];
    load_half = payload_q.adrl[1] ? payload_q.dm[31:16] : payload_q.dm[15:0];
    if (payload_q.lubhw[0])      load_data = {{24{load_byte[7]}}, load_byte};
    else if (payload_q.lubhw[1]) load_data = {24'h0, load_byte};
    else if (payload_q.lubhw[2]) load_data = {{16{load_half[15]}}, load_half};
    else if (payload_q.lubhw[3]) load_data = {16'h0, load_half};
    else                         load_data = payload_q.dm;
  end

  // LWL shifts the word up into the high bytes, LWR down into the low bytes.
  always_comb begin
    case (payload_q.onehot)
      8'h01:   llr_data = payload_q.dm << 24;
      8'h02:   llr_data = payload_q.dm << 16;
      8'h04:   llr_data = payload_q.dm << 8;
      8'h08:   llr_data = payload_q.dm;
      8'h10:   llr_data = payload_q.dm;
      8'h20:   llr_data = payload_q.dm >> 8;
      8'h40:   llr_data = payload_q.dm >> 16;
      8'h80:   llr_data = payload_q.dm >> 24;
      default: llr_data = 32'h0;
    endcase
  end

  always_comb begin
    if (payload_q.sel[2])         wdata = llr_data;
    else if (payload_q.sel[1])    wdata = load_data;
    else if (payload_q.mftc0_op[0]) wdata = cp0_rdata_in;
    else                          wdata = payload_q.wbdata;

    if (payload_q.sel[2])       we_raw = payload_q.llr_we;
    else if (payload_q.wr_gpr)  we_raw = 4'hF;
    else                        we_raw = 4'h0;
  end

  always_comb begin
    rf_we_out        = 4'h0;
    rf_waddr_out     = 5'h0;
    rf_wdata_out     = 32'h0;
    cp0_addr_out     = 8'h0;
    cp0_we_out       = 1'b0;
    cp0_wdata_out    = 32'h0;
    cp0_ExcCode_out  = 5'h0;
    cp0_bd_out       = 1'b0;
    cp0_epc_out      = 32'h0;
    cp0_badvaddr_out = 32'h0;
    if (commit) begin
      if (!payload_q.exception && !payload_q.eret && payload_q.wnum != 5'd0)
        rf_we_out = we_raw;
      rf_waddr_out     = payload_q.wnum;
      rf_wdata_out     = wdata;
      cp0_addr_out     = payload_q.cp0_addr;
      cp0_we_out       = payload_q.mftc0_op[1] & ~payload_q.exception;
      cp0_wdata_out    = payload_q.mtc0_data;
      cp0_ExcCode_out  = payload_q.exc_code;
      cp0_bd_out       = payload_q.bd;
      cp0_epc_out      = payload_q.pc;
      cp0_badvaddr_out = payload_q.err_vaddr;
    end
  end

  generate
    if (TRACE_EN) begin : g_trace
      assign debug_wb_pc       = commit ? payload_q.pc : 32'h0;
      assign debug_wb_rf_wen   = rf_we_out;
      assign debug_wb_rf_wnum  = rf_waddr_out;
      assign debug_wb_rf_wdata = rf_wdata_out;
    end else begin : g_no_trace
      assign debug_wb_pc       = 32'h0;
      assign debug_wb_rf_wen   = 4'h0;
      assign debug_wb_rf_wnum  = 5'h0;
      assign debug_wb_rf_wdata = 32'h0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, load alignment, LWL/LWR, CP0 commit, flush and back-to-back flow.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_valid_in;
  logic        wb_allowin_out;
  logic [31:0] mem_PC_in;
  logic [31:0] mem_dm_data_in;
  logic [4:0]  mem_wnum_in;
  logic [2:0]  mem_sel_wbdata_in;
  logic [7:0]  mem_onehot_in;
  logic [4:0]  mem_lubhw_con_in;
  logic [1:0]  mem_adrl_in;
  logic [2:0]  mem_write_type_in;
  logic [31:0] mem_wbdata_in;
  logic [3:0]  mem_llr_we_in;
  logic        mem_exception_in;
  logic        mem_bd_in;
  logic        mem_eret_in;
  logic [4:0]  mem_ExcCode_in;
  logic [7:0]  mem_cp0_addr_in;
  logic [31:0] mem_mtc0_data_in;
  logic [31:0] mem_error_VAddr_in;
  logic [1:0]  mem_mftc0_op_in;
  logic [31:0] cp0_rdata_in;
  logic [3:0]  rf_we_out;
  logic [4:0]  rf_waddr_out;
  logic [31:0] rf_wdata_out;
  logic [7:0]  cp0_addr_out;
  logic        cp0_we_out;
  logic [31:0] cp0_wdata_out;
  logic        cp0_exc_out;
  logic        cp0_eret_out;
  logic [4:0]  cp0_ExcCode_out;
  logic        cp0_bd_out;
  logic [31:0] cp0_epc_out;
  logic [31:0] cp0_badvaddr_out;
  logic [1:0]  wb_ClrStpJmp_out;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks;
  int errors;

  wb_stage #(.TRACE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_in(mem_valid_in), .wb_allowin_out(wb_allowin_out),
    .mem_PC_in(mem_PC_in), .mem_dm_data_in(mem_dm_data_in),
    .mem_wnum_in(mem_wnum_in), .mem_sel_wbdata_in(mem_sel_wbdata_in),
    .mem_onehot_in(mem_onehot_in), .mem_lubhw_con_in(mem_lubhw_con_in),
    .mem_adrl_in(mem_adrl_in), .mem_write_type_in(mem_write_type_in),
    .mem_wbdata_in(mem_wbdata_in), .mem_llr_we_in(mem_llr_we_in),
    .mem_exception_in(mem_exception_in), .mem_bd_in(mem_bd_in),
    .mem_eret_in(mem_eret_in), .mem_ExcCode_in(mem_ExcCode_in),
    .mem_cp0_addr_in(mem_cp0_addr_in), .mem_mtc0_data_in(mem_mtc0_data_in),
    .mem_error_VAddr_in(mem_error_VAddr_in), .mem_mftc0_op_in(mem_mftc0_op_in),
    .cp0_rdata_in(cp0_rdata_in),
    .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out), .rf_wdata_out(rf_wdata_out),
    .cp0_addr_out(cp0_addr_out), .cp0_we_out(cp0_we_out), .cp0_wdata_out(cp0_wdata_out),
    .cp0_exc_out(cp0_exc_out), .cp0_eret_out(cp0_eret_out),
    .cp0_ExcCode_out(cp0_ExcCode_out), .cp0_bd_out(cp0_bd_out),
    .cp0_epc_out(cp0_epc_out), .cp0_badvaddr_out(cp0_badvaddr_out),
    .wb_ClrStpJmp_out(wb_ClrStpJmp_out),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_in();
    mem_valid_in       = 1'b0;
    mem_PC_in          = 32'h0;
    mem_dm_data_in     = 32'h0;
    mem_wnum_in        = 5'h0;
    mem_sel_wbdata_in  = 3'h0;
    mem_onehot_in      = 8'h0;
    mem_lubhw_con_in   = 5'h0;
    mem_adrl_in        = 2'h0;
    mem_write_type_in  = 3'h0;
    mem_wbdata_in      = 32'h0;
    mem_llr_we_in      = 4'h0;
    mem_exception_in   = 1'b0;
    mem_bd_in          = 1'b0;
    mem_eret_in        = 1'b0;
    mem_ExcCode_in     = 5'h0;
    mem_cp0_addr_in    = 8'h0;
    mem_mtc0_data_in   = 32'h0;
    mem_error_VAddr_in = 32'h0;
    mem_mftc0_op_in    = 2'h0;
  endtask

  // One edge: the driven instruction is captured and commits in the cycle sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [4:0] lubhw, input logic [1:0] adrl,
                            input logic [31:0] dm, input logic [4:0] wnum);
    clear_in();
    mem_valid_in      = 1'b1;
    mem_PC_in         = 32'hBFC0_0010;
    mem_sel_wbdata_in = 3'b010;
    mem_lubhw_con_in  = lubhw;
    mem_adrl_in       = adrl;
    mem_dm_data_in    = dm;
    mem_wnum_in       = wnum;
    mem_write_type_in = 3'b001;
  endtask

  task automatic drive_llr(input logic [7:0] onehot, input logic [31:0] dm, input logic [3:0] llr_we);
    clear_in();
    mem_valid_in      = 1'b1;
    mem_PC_in         = 32'hBFC0_0020;
    mem_sel_wbdata_in = 3'b100;
    mem_onehot_in     = onehot;
    mem_dm_data_in    = dm;
    mem_llr_we_in     = llr_we;
    mem_wnum_in       = 5'd9;
    mem_write_type_in = 3'b001;
  endtask

  task automatic drive_alu(input logic [31:0] pc, input logic [31:0] data, input logic [4:0] wnum);
    clear_in();
    mem_valid_in      = 1'b1;
    mem_PC_in         = pc;
    mem_sel_wbdata_in = 3'b001;
    mem_wbdata_in     = data;
    mem_wnum_in       = wnum;
    mem_write_type_in = 3'b001;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cp0_rdata_in = 32'h0;

    // reset held with a live instruction on the input
    rst_n = 1'b0;
    drive_alu(32'hBFC0_0000, 32'h1111_2222, 5'd5);
    repeat (3) step();
    check("rst_allowin", {31'h0, wb_allowin_out}, 32'h0);
    check("rst_rf_we", {28'h0, rf_we_out}, 32'h0);
    check("rst_wdata", rf_wdata_out, 32'h0);
    check("rst_clr", {30'h0, wb_ClrStpJmp_out}, 32'h0);
    check("rst_dbg_pc", debug_wb_pc, 32'h0);
    rst_n = 1'b1;
    clear_in();
    #1;
    check("allowin_after_rst", {31'h0, wb_allowin_out}, 32'h1);
    step();
    check("bubble_rf_we", {28'h0, rf_we_out}, 32'h0);

    // load alignment
    drive_load(5'b00001, 2'd2, 32'h1285_3456, 5'd3);
    step();
    check("lb_wdata", rf_wdata_out, 32'hFFFF_FF85);
    check("lb_we", {28'h0, rf_we_out}, 32'hF);
    check("lb_waddr", {27'h0, rf_waddr_out}, 32'd3);
    check("lb_dbg_wdata", debug_wb_rf_wdata, 32'hFFFF_FF85);
    check("lb_dbg_pc", debug_wb_pc, 32'hBFC0_0010);
    drive_load(5'b00010, 2'd2, 32'h1285_3456, 5'd3);
    step();
    check("lbu_wdata", rf_wdata_out, 32'h0000_0085);
    drive_load(5'b00100, 2'd2, 32'h8285_3456, 5'd3);
    step();
    check("lh_hi_wdata", rf_wdata_out, 32'hFFFF_8285);
    drive_load(5'b01000, 2'd0, 32'h1285_8001, 5'd3);
    step();
    check("lhu_lo_wdata", rf_wdata_out, 32'h0000_8001);
    drive_load(5'b10000, 2'd0, 32'hCAFE_F00D, 5'd3);
    step();
    check("lw_wdata", rf_wdata_out, 32'hCAFE_F00D);

    // LWL / LWR merge
    drive_llr(8'h02, 32'hAABB_CCDD, 4'b1100);
    step();
    check("lwl1_wdata", rf_wdata_out, 32'hCCDD_0000);
    check("lwl1_we", {28'h0, rf_we_out}, 32'hC);
    drive_llr(8'h40, 32'hAABB_CCDD, 4'b0011);
    step();
    check("lwr2_wdata", rf_wdata_out, 32'h0000_AABB);
    check("lwr2_we", {28'h0, rf_we_out}, 32'h3);

    // exception commit, then a younger instruction that must be dropped
    drive_alu(32'hBFC0_0100, 32'h5555_5555, 5'd4);
    mem_exception_in   = 1'b1;
    mem_ExcCode_in     = 5'h04;
    mem_bd_in          = 1'b1;
    mem_error_VAddr_in = 32'h0000_1003;
    step();
    check("exc_clr", {30'h0, wb_ClrStpJmp_out}, 32'h1);
    check("exc_cp0_exc", {31'h0, cp0_exc_out}, 32'h1);
    check("exc_rf_we", {28'h0, rf_we_out}, 32'h0);
    check("exc_code", {27'h0, cp0_ExcCode_out}, 32'h4);
    check("exc_epc", cp0_epc_out, 32'hBFC0_0100);
    check("exc_bd", {31'h0, cp0_bd_out}, 32'h1);
    check("exc_badvaddr", cp0_badvaddr_out, 32'h0000_1003);
    drive_alu(32'hBFC0_0104, 32'h7777_7777, 5'd7);
    step();
    check("flush_rf_we", {28'h0, rf_we_out}, 32'h0);
    check("flush_dbg_pc", debug_wb_pc, 32'h0);
    check("flush_clr", {30'h0, wb_ClrStpJmp_out}, 32'h0);

    // ERET alone, then ERET + exception
    drive_alu(32'hBFC0_0200, 32'h0, 5'd0);
    mem_write_type_in = 3'b000;
    mem_eret_in = 1'b1;
    step();
    check("eret_clr", {30'h0, wb_ClrStpJmp_out}, 32'h2);
    check("eret_out", {31'h0, cp0_eret_out}, 32'h1);
    clear_in();
    step();
    drive_alu(32'hBFC0_0300, 32'h0, 5'd0);
    mem_eret_in = 1'b1;
    mem_exception_in = 1'b1;
    step();
    check("eret_exc_clr", {30'h0, wb_ClrStpJmp_out}, 32'h1);
    check("eret_exc_eret", {31'h0, cp0_eret_out}, 32'h0);
    clear_in();
    step();

    // MTC0 plain and with exception, MFC0 read-back path
    drive_alu(32'hBFC0_0400, 32'h0, 5'd0);
    mem_write_type_in = 3'b000;
    mem_mftc0_op_in   = 2'b10;
    mem_cp0_addr_in   = {5'd12, 3'd0};
    mem_mtc0_data_in  = 32'h0040_FF01;
    step();
    check("mtc0_we", {31'h0, cp0_we_out}, 32'h1);
    check("mtc0_wdata", cp0_wdata_out, 32'h0040_FF01);
    check("mtc0_addr", {24'h0, cp0_addr_out}, 32'h60);
    mem_exception_in = 1'b1;
    step();
    check("mtc0_exc_we", {31'h0, cp0_we_out}, 32'h0);
    clear_in();
    step();
    drive_alu(32'hBFC0_0500, 32'h1234_5678, 5'd8);
    mem_sel_wbdata_in = 3'b001;
    mem_mftc0_op_in   = 2'b01;
    cp0_rdata_in      = 32'hDEAD_BEEF;
    step();
    check("mfc0_wdata", rf_wdata_out, 32'hDEAD_BEEF);
    check("mfc0_we", {28'h0, rf_we_out}, 32'hF);

    // write to $0 is suppressed
    drive_alu(32'hBFC0_0600, 32'hFFFF_FFFF, 5'd0);
    step();
    check("wnum0_we", {28'h0, rf_we_out}, 32'h0);

    // back-to-back stream, one commit per cycle
    for (int i = 0; i < 4; i++) begin
      drive_alu(32'hBFC0_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 5'(i + 1));
      step();
      check("b2b_wdata", rf_wdata_out, 32'hA000_0000 + 32'(i));
      check("b2b_waddr", {27'h0, rf_waddr_out}, 32'(i + 1));
      check("b2b_pc", debug_wb_pc, 32'hBFC0_1000 + 32'(4 * i));
      check("b2b_we", {28'h0, rf_we_out}, 32'hF);
    end
    clear_in();
    step();
    check("tail_bubble_we", {28'h0, rf_we_out}, 32'h0);
    check("tail_bubble_pc", debug_wb_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
